// File: rtl/obi_data_mem_responder.sv
// OBI data-side responder: word-addressed RAM with byte-enable writes, configurable
// grant delay, fixed-latency in-order responses and an outstanding-transaction limit.
module obi_data_mem_responder #(
  parameter int          MEM_WORDS       = 1024,
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
  parameter int          GNT_DELAY       = 0,
  parameter int          RVALID_LATENCY  = 1,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  input  logic [31:0] data_addr_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  input  logic        stall_i,
  output logic [3:0]  outstanding_o
);

  localparam int          IDX_W     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) << 2;
  localparam logic [7:0]  GNT_DLY_C = 8'(GNT_DELAY);
  localparam logic [3:0]  MAX_OUT_C = 4'(MAX_OUTSTANDING);

  logic [31:0]               mem [MEM_WORDS];
  logic [7:0]                wait_cnt;
  logic [3:0]                outstanding;
  logic [RVALID_LATENCY-1:0] pipe_valid;
  logic [RVALID_LATENCY-1:0] pipe_err;
  logic [31:0]               pipe_data [RVALID_LATENCY];

  logic [31:0]      offset;
  logic             in_range;
  logic [IDX_W-1:0] idx;
  logic             grant;
  logic             retire;
  logic [31:0]      rd_word;

  // Offset compare is done in 33 bits so a window ending at 4 GiB cannot wrap.
  assign offset   = data_addr_i - BASE_ADDR;
  assign in_range = (data_addr_i >= BASE_ADDR) && ({1'b0, offset} < MEM_BYTES);
  assign idx      = offset[IDX_W+1:2];
  assign retire   = pipe_valid[RVALID_LATENCY-1];

  // No same-cycle credit reuse: a retiring response does not free a slot until next cycle.
  assign grant = data_req_i && !stall_i && (wait_cnt == GNT_DLY_C) && (outstanding < MAX_OUT_C);
  assign rd_word = (grant && in_range && !data_we_i) ? mem[idx] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (!data_req_i || grant) begin
      wait_cnt <= '0;
    end else if (!stall_i && (wait_cnt < GNT_DLY_C)) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  // Memory contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (grant && data_we_i && in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (data_be_i[i]) begin
          mem[idx][8*i +: 8] <= data_wdata_i[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_valid <= '0;
      pipe_err   <= '0;
      for (int i = 0; i < RVALID_LATENCY; i++) begin
        pipe_data[i] <= '0;
      end
    end else begin
      pipe_valid[0] <= grant;
      pipe_err[0]   <= grant && !in_range;
      pipe_data[0]  <= rd_word;
      for (int i = 1; i < RVALID_LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_err[i]   <= pipe_err[i-1];
        pipe_data[i]  <= pipe_data[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding <= '0;
    end else begin
      case ({grant, retire})
        2'b10:   outstanding <= outstanding + 4'd1;
        2'b01:   outstanding <= outstanding - 4'd1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  assign data_gnt_o    = grant;
  assign data_rvalid_o = retire;
  assign data_rdata_o  = retire ? pipe_data[RVALID_LATENCY-1] : '0;
  assign data_err_o    = retire && pipe_err[RVALID_LATENCY-1];
  assign outstanding_o = outstanding;

endmodule

// File: tb/tb_obi_data_mem_responder.sv
// Bench for obi_data_mem_responder: directed scenarios plus random traffic, all checked
// every cycle against a timestamped response-queue model of the responder.
module tb_obi_data_mem_responder;

  localparam int          MEM_WORDS = 256;
  localparam logic [31:0] BASE      = 32'h0000_1000;
  localparam int          GNT_DELAY = 1;
  localparam int          LATENCY   = 4;
  localparam int          MAX_OUT   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        gnt;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;
  logic        stall;
  logic [3:0]  outstanding;

  obi_data_mem_responder #(
    .MEM_WORDS(MEM_WORDS), .BASE_ADDR(BASE), .GNT_DELAY(GNT_DELAY),
    .RVALID_LATENCY(LATENCY), .MAX_OUTSTANDING(MAX_OUT)
  ) dut (
    .clk(clk), .rst(rst), .data_req_i(req), .data_gnt_o(gnt), .data_addr_i(addr),
    .data_we_i(we), .data_be_i(be), .data_wdata_i(wdata), .data_rvalid_o(rvalid),
    .data_rdata_o(rdata), .data_err_o(err), .stall_i(stall), .outstanding_o(outstanding)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] data;
    logic        err;
  } resp_t;

  logic [31:0] ref_mem [MEM_WORDS];
  resp_t       ref_q [$];
  int          held_cycles = 0;
  int          cyc = 0;
  bit          model_gnt = 1'b0;

  int          total_checks = 0;
  int          bad_checks = 0;
  logic        obs_gnt;
  logic [31:0] last_rdata;
  logic        last_err;
  int          rv_count;
  int          max_out;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total_checks++;
    if (observed !== expected) begin
      bad_checks++;
      $display("[TB] FAIL %s (cycle %0d): observed %h expected %h", tag, cyc, observed, expected);
    end
  endtask

  // One bus cycle: drive inputs, compare every output with the model, then advance the model.
  task automatic applyStimulus(input logic r, input logic [31:0] a, input logic w,
                               input logic [3:0] b, input logic [31:0] d,
                               input logic s, input logic rs);
    bit          exp_rv;
    bit          exp_gnt;
    bit          ok;
    int          idx;
    logic [31:0] word;
    @(negedge clk);
    req = r; addr = a; we = w; be = b; wdata = d; stall = s; rst = rs;
    #2;
    exp_rv  = (ref_q.size() > 0) && (ref_q[0].due == cyc);
    exp_gnt = r && !s && (held_cycles == GNT_DELAY) && (ref_q.size() < MAX_OUT);
    checkOutput("gnt", 32'(gnt), 32'(exp_gnt));
    checkOutput("rvalid", 32'(rvalid), 32'(exp_rv));
    checkOutput("rdata", rdata, exp_rv ? ref_q[0].data : 32'h0);
    checkOutput("err", 32'(err), exp_rv ? 32'(ref_q[0].err) : 32'h0);
    checkOutput("outstanding", 32'(outstanding), 32'(ref_q.size()));
    obs_gnt = gnt;
    if (rvalid === 1'b1) begin
      last_rdata = rdata;
      last_err   = err;
      rv_count++;
    end
    if (int'(outstanding) > max_out) max_out = int'(outstanding);
    @(posedge clk);
    if (rs) begin
      ref_q.delete();
      held_cycles = 0;
    end else begin
      if (exp_rv) void'(ref_q.pop_front());
      if (exp_gnt) begin
        ok   = (longint'(a) >= longint'(BASE)) && (longint'(a) < longint'(BASE) + 4 * MEM_WORDS);
        idx  = ok ? int'((a - BASE) >> 2) : 0;
        word = 32'h0;
        if (ok && w) begin
          for (int i = 0; i < 4; i++)
            if (b[i]) ref_mem[idx][8*i +: 8] = d[8*i +: 8];
        end else if (ok) begin
          word = ref_mem[idx];
        end
        ref_q.push_back('{due: cyc + LATENCY, data: word, err: !ok});
      end
      if (!r || exp_gnt) held_cycles = 0;
      else if (!s && held_cycles < GNT_DELAY) held_cycles++;
    end
    model_gnt = exp_gnt;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0);
  endtask

  // Hold a request until the model grants it; reports how many cycles the DUT took to grant.
  task automatic doTxn(input logic [31:0] a, input logic w, input logic [3:0] b,
                       input logic [31:0] d, output int dut_wait);
    dut_wait = -1;
    for (int k = 0; k < 20; k++) begin
      applyStimulus(1'b1, a, w, b, d, 1'b0, 1'b0);
      if (obs_gnt === 1'b1 && dut_wait < 0) dut_wait = k;
      if (model_gnt) break;
    end
  endtask

  initial begin
    int          wt;
    logic        cur_req;
    logic [31:0] cur_addr;
    logic        cur_we;
    logic [3:0]  cur_be;
    logic [31:0] cur_wdata;
    int          sel;

    rst = 1'b1; req = 1'b0; addr = '0; we = 1'b0; be = '0; wdata = '0; stall = 1'b0;
    repeat (2) @(posedge clk);
    idle(2);

    for (int i = 0; i < 16; i++) doTxn(BASE + 32'(4 * i), 1'b1, 4'hF, $urandom, wt);
    idle(LATENCY + 1);

    doTxn(BASE + 32'h10, 1'b1, 4'hF, 32'hDEAD_BEEF, wt);
    doTxn(BASE + 32'h10, 1'b0, 4'hF, 32'h0, wt);
    idle(LATENCY + 1);
    checkOutput("raw_rdata", last_rdata, 32'hDEAD_BEEF);
    checkOutput("raw_err", 32'(last_err), 32'h0);

    doTxn(BASE + 32'h20, 1'b1, 4'hF, 32'h1122_3344, wt);
    doTxn(BASE + 32'h20, 1'b1, 4'b0101, 32'hAABB_CCDD, wt);
    doTxn(BASE + 32'h21, 1'b0, 4'hF, 32'h0, wt);
    idle(LATENCY + 1);
    checkOutput("byte_enable", last_rdata, 32'h11BB_33DD);

    doTxn(BASE + 32'h4, 1'b0, 4'hF, 32'h0, wt);
    checkOutput("gnt_delay", 32'(wt), 32'(GNT_DELAY));
    idle(LATENCY + 1);
    applyStimulus(1'b1, BASE + 32'h8, 1'b0, 4'hF, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, BASE + 32'h8, 1'b0, 4'hF, 32'h0, 1'b0, 1'b0);
    doTxn(BASE + 32'h8, 1'b0, 4'hF, 32'h0, wt);
    checkOutput("gnt_after_withdraw", 32'(wt), 32'(GNT_DELAY));
    idle(LATENCY + 1);

    rv_count = 0; max_out = 0;
    doTxn(BASE + 32'h0, 1'b0, 4'hF, 32'h0, wt);
    doTxn(BASE + 32'h4, 1'b0, 4'hF, 32'h0, wt);
    doTxn(BASE + 32'h8, 1'b0, 4'hF, 32'h0, wt);
    checkOutput("third_gnt_blocked", 32'(wt), 32'(GNT_DELAY + 1));
    idle(LATENCY + 2);
    checkOutput("max_outstanding", 32'(max_out), 32'(MAX_OUT));
    checkOutput("rvalid_count", 32'(rv_count), 32'd3);

    doTxn(BASE + 32'(4 * MEM_WORDS), 1'b0, 4'hF, 32'h0, wt);
    idle(LATENCY + 1);
    checkOutput("oor_read_err", 32'(last_err), 32'h1);
    checkOutput("oor_read_rdata", last_rdata, 32'h0);
    doTxn(32'hFFFF_FFFC, 1'b1, 4'hF, 32'h5555_AAAA, wt);
    idle(LATENCY + 1);
    checkOutput("oor_write_err", 32'(last_err), 32'h1);
    doTxn(BASE, 1'b0, 4'hF, 32'h0, wt);
    idle(LATENCY + 1);
    checkOutput("word0_intact", last_rdata, ref_mem[0]);

    rv_count = 0;
    doTxn(BASE + 32'h10, 1'b0, 4'hF, 32'h0, wt);
    applyStimulus(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b1);
    idle(LATENCY + 2);
    checkOutput("rvalid_after_reset", 32'(rv_count), 32'h0);
    checkOutput("outstanding_after_reset", 32'(outstanding), 32'h0);
    doTxn(BASE + 32'h10, 1'b0, 4'hF, 32'h0, wt);
    idle(LATENCY + 1);
    checkOutput("mem_kept_over_reset", last_rdata, 32'hDEAD_BEEF);

    cur_req = 1'b0; cur_addr = '0; cur_we = 1'b0; cur_be = '0; cur_wdata = '0;
    for (int c = 0; c < 800; c++) begin
      if (!cur_req || model_gnt) begin
        cur_req = ($urandom_range(0, 3) != 0);
        sel = $urandom_range(0, 9);
        if (sel == 0)      cur_addr = BASE + 32'(4 * MEM_WORDS) + 32'(4 * $urandom_range(0, 15));
        else if (sel == 1) cur_addr = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFC : BASE - 32'h4;
        else               cur_addr = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
        cur_we    = ($urandom_range(0, 1) == 1);
        cur_be    = 4'($urandom_range(0, 15));
        cur_wdata = $urandom;
      end else if ($urandom_range(0, 39) == 0) begin
        cur_req = 1'b0;
      end
      applyStimulus(cur_req, cur_addr, cur_we, cur_be, cur_wdata, $urandom_range(0, 5) == 0, 1'b0);
    end
    idle(LATENCY + 2);

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
